// File: rtl/io_read_port_scheduler.sv
// io_read_port_scheduler: decodes I/O read-port addresses per issuing thread,
// emits a one-cycle-latency ack or annul, and tracks per-thread stall runs.
module io_read_port_scheduler #(
   parameter int unsigned ADDR_WIDTH              = 10,
   parameter int unsigned IO_READ_PORT_BASE_ADDR  = 1016,
   parameter int unsigned IO_READ_PORT_COUNT      = 8,
   parameter int unsigned IO_READ_PORT_ADDR_WIDTH = 3,
   parameter int unsigned THREAD_COUNT            = 8,
   parameter int unsigned THREAD_ID_WIDTH         = 3,
   parameter int unsigned STALL_LIMIT             = 15,
   parameter int unsigned STALL_COUNT_WIDTH       = 4
) (
   input  logic                               clock,
   input  logic                               reset_n,
   input  logic [ADDR_WIDTH-1:0]              read_addr_in,
   input  logic                               read_en_in,
   input  logic [IO_READ_PORT_COUNT-1:0]      read_rdy_in,
   output logic [IO_READ_PORT_COUNT-1:0]      read_ack_out,
   output logic [IO_READ_PORT_ADDR_WIDTH-1:0] port_addr_out,
   output logic                               io_sel_out,
   output logic                               annul_out,
   output logic [THREAD_ID_WIDTH-1:0]         thread_out,
   output logic [THREAD_COUNT-1:0]            timeout_out
);

   // One extra bit so a window ending at 2^ADDR_WIDTH cannot alias to 0.
   localparam int unsigned CMP_WIDTH = ADDR_WIDTH + 1;
   localparam int unsigned WIN_END   = IO_READ_PORT_BASE_ADDR + IO_READ_PORT_COUNT;
   localparam int unsigned PORT_SPAN = 1 << IO_READ_PORT_ADDR_WIDTH;

   logic [CMP_WIDTH-1:0]               addr_ext_c;
   logic                               hit_c;
   logic [IO_READ_PORT_ADDR_WIDTH-1:0] idx_c;
   logic [PORT_SPAN-1:0]               rdy_vec_c;
   logic                               rdy_c;
   logic [IO_READ_PORT_COUNT-1:0]      ack_c;

   logic [THREAD_ID_WIDTH-1:0]         thread_cnt;
   logic [STALL_COUNT_WIDTH-1:0]       stall_cnt [THREAD_COUNT];

   // Stage 0: window decode, port index and ready sample for this cycle.
   always_comb begin
      addr_ext_c = CMP_WIDTH'(read_addr_in);
      hit_c      = read_en_in
                   && (addr_ext_c >= CMP_WIDTH'(IO_READ_PORT_BASE_ADDR))
                   && (addr_ext_c <  CMP_WIDTH'(WIN_END));
      idx_c      = IO_READ_PORT_ADDR_WIDTH'(read_addr_in - ADDR_WIDTH'(IO_READ_PORT_BASE_ADDR));
      rdy_vec_c  = PORT_SPAN'(read_rdy_in);
      rdy_c      = rdy_vec_c[idx_c];
      ack_c      = '0;
      if (hit_c && rdy_c) begin
         ack_c = IO_READ_PORT_COUNT'(1) << idx_c;
      end
   end

   // Stage 1: registered result, aligned to the one-cycle RAM latency.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         read_ack_out  <= '0;
         port_addr_out <= '0;
         io_sel_out    <= 1'b0;
         annul_out     <= 1'b0;
         thread_out    <= '0;
      end else begin
         read_ack_out  <= ack_c;
         port_addr_out <= hit_c ? idx_c : '0;
         io_sel_out    <= hit_c;
         annul_out     <= hit_c && !rdy_c;
         thread_out    <= thread_cnt;
      end
   end

   // Round-robin issuing-thread counter.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         thread_cnt <= '0;
      end else if (thread_cnt == THREAD_ID_WIDTH'(THREAD_COUNT - 1)) begin
         thread_cnt <= '0;
      end else begin
         thread_cnt <= thread_cnt + THREAD_ID_WIDTH'(1);
      end
   end

   // Consecutive-annul counter of the issuing thread; saturates at the limit.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int t = 0; t < THREAD_COUNT; t++) begin
            stall_cnt[t] <= '0;
         end
      end else if (hit_c && !rdy_c) begin
         if (stall_cnt[thread_cnt] != STALL_COUNT_WIDTH'(STALL_LIMIT)) begin
            stall_cnt[thread_cnt] <= stall_cnt[thread_cnt] + STALL_COUNT_WIDTH'(1);
         end
      end else begin
         stall_cnt[thread_cnt] <= '0;
      end
   end

   // Timeout flag follows its counter one cycle later.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         timeout_out <= '0;
      end else begin
         for (int t = 0; t < THREAD_COUNT; t++) begin
            timeout_out[t] <= (stall_cnt[t] == STALL_COUNT_WIDTH'(STALL_LIMIT));
         end
      end
   end

endmodule

// File: tb/tb_io_read_port_scheduler.sv
// Scoreboard bench for io_read_port_scheduler with a queue-based reference model.
module tb_io_read_port_scheduler;

   logic       clock;
   logic       reset_n;
   logic [9:0] read_addr_in;
   logic       read_en_in;
   logic [7:0] read_rdy_in;
   logic [7:0] read_ack_out;
   logic [2:0] port_addr_out;
   logic       io_sel_out;
   logic       annul_out;
   logic [2:0] thread_out;
   logic [7:0] timeout_out;

   typedef struct packed {
      logic [7:0] ack;
      logic [2:0] port;
      logic       iosel;
      logic       annul;
      logic [2:0] thr;
      logic [7:0] tmo;
   } exp_t;

   exp_t q[$];
   int   checks;
   int   errors;
   int   mt;
   int   cnt[8];

   io_read_port_scheduler dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .read_addr_in  (read_addr_in),
      .read_en_in    (read_en_in),
      .read_rdy_in   (read_rdy_in),
      .read_ack_out  (read_ack_out),
      .port_addr_out (port_addr_out),
      .io_sel_out    (io_sel_out),
      .annul_out     (annul_out),
      .thread_out    (thread_out),
      .timeout_out   (timeout_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input int got, input int expv);
      checks++;
      if (got != expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, expv, $time);
      end
   endtask

   task automatic model_reset();
      mt = 0;
      for (int t = 0; t < 8; t++) cnt[t] = 0;
      q.delete();
   endtask

   // Drive one issue slot and push the result the next edge must produce.
   task automatic issue(input bit en, input int addr, input logic [7:0] rdy);
      exp_t e;
      bit   hit;
      bit   r;
      int   idx;
      read_en_in   = en;
      read_addr_in = 10'(addr);
      read_rdy_in  = rdy;
      hit = en && (addr >= 1016) && (addr < 1024);
      idx = hit ? addr - 1016 : 0;
      r   = rdy[idx];
      e       = '0;
      e.iosel = hit;
      e.port  = 3'(idx);
      e.thr   = 3'(mt);
      if (hit && r) e.ack = 8'(1) << idx;
      e.annul = hit && !r;
      for (int t = 0; t < 8; t++) e.tmo[t] = (cnt[t] >= 15);
      if (hit && !r) cnt[mt] = (cnt[mt] < 15) ? cnt[mt] + 1 : 15;
      else           cnt[mt] = 0;
      mt = (mt + 1) % 8;
      q.push_back(e);
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic step(input bit en, input int addr, input logic [7:0] rdy);
      issue(en, addr, rdy);
      @(negedge clock);
   endtask

   task automatic rand_step();
      int a;
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(1012, 1023));
      step($urandom_range(0, 3) != 0, a, 8'($urandom));
   endtask

   // Hold reset for n cycles with toggling inputs, release at a falling edge.
   task automatic do_reset(input int n);
      reset_n = 1'b0;
      model_reset();
      repeat (n) begin
         read_addr_in = 10'($urandom);
         read_en_in   = 1'($urandom);
         read_rdy_in  = 8'($urandom);
         @(negedge clock);
      end
      reset_n = 1'b1;
   endtask

   // Monitor: compare every edge's outputs against the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (!reset_n) begin
            chk("rst_ack", read_ack_out, 0);
            chk("rst_sel", io_sel_out, 0);
            chk("rst_annul", annul_out, 0);
            chk("rst_port", port_addr_out, 0);
            chk("rst_thr", thread_out, 0);
            chk("rst_tmo", timeout_out, 0);
         end else if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got no expected entry at %0t", $time);
         end else begin
            e = q.pop_front();
            chk("ack", read_ack_out, e.ack);
            chk("port", port_addr_out, e.port);
            chk("io_sel", io_sel_out, e.iosel);
            chk("annul", annul_out, e.annul);
            chk("thread", thread_out, e.thr);
            chk("timeout", timeout_out, e.tmo);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish by 2000000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int turns;
      checks       = 0;
      errors       = 0;
      reset_n      = 1'b0;
      read_addr_in = '0;
      read_en_in   = 1'b0;
      read_rdy_in  = '0;
      model_reset();
      @(negedge clock);
      do_reset(4);

      // Thread sequence after release, idle slots.
      repeat (9) step(0, 0, 8'h00);

      // Directed window cases.
      step(1, 1018, 8'b0000_0100);
      step(0, 0, 8'h00);
      step(1, 1023, 8'h7F);
      step(1, 1023, 8'hFF);
      step(1, 1015, 8'hFF);
      step(1, 5, 8'hFF);
      step(0, 1016, 8'hFF);
      step(1, 1016, 8'h00);
      step(1, 1016, 8'h01);

      // Thread 3 stalls on port 0 for 15 turns, then succeeds.
      do_reset(2);
      turns = 0;
      while (turns < 16) begin
         if (mt == 3) begin
            step(1, 1016, (turns < 15) ? 8'h00 : 8'h01);
            turns++;
         end else begin
            step(0, 0, 8'hFF);
         end
      end
      repeat (8) step(0, 0, 8'h00);

      repeat (3000) rand_step();

      // Reset while an ack is being presented.
      issue(1, 1018, 8'b0000_0100);
      @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      chk("midrst_ack", read_ack_out, 0);
      chk("midrst_sel", io_sel_out, 0);
      model_reset();
      @(negedge clock);
      do_reset(2);
      repeat (4) step(0, 1018, 8'hFF);

      repeat (1000) rand_step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
